// File: rtl/sram_emulator.sv
// Clocked stand-in for an asynchronous 256K x 16 SRAM: responds to controller pins from an
// internal array with programmable read latency and flags short writes and bus contention.
module sram_emulator #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 3,
    parameter int WRITE_MIN  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address_pins,
    input  logic [DATA_W-1:0] data_pins_in,
    input  logic              data_pins_in_en,
    input  logic              OE,
    input  logic              WE,
    input  logic              CS,
    output logic [DATA_W-1:0] data_pins_out,
    output logic              data_pins_out_en,
    output logic [15:0]       write_count,
    output logic [15:0]       read_count,
    output logic              err_short_write,
    output logic              err_contention,
    input  logic              clear_errors
);

    localparam int         DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [2:0] READ_LAT_C  = 3'(READ_LAT);
    localparam logic [2:0] WRITE_MIN_C = 3'(WRITE_MIN);
    localparam logic [2:0] CNT_MAX     = 3'd7;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_ACCESS = 2'd1,
        READ_VALID  = 2'd2,
        WRITE       = 2'd3
    } state_t;

    state_t            state_r;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic sel_s;
    logic wr_s;
    logic rd_s;
    logic addr_chg_s;
    logic write_end_s;
    logic commit_s;
    logic short_s;
    logic contention_s;

    // Pin decode and per-cycle event detection
    always_comb begin
        sel_s        = ~CS;
        wr_s         = sel_s & ~WE;
        rd_s         = sel_s & WE & ~OE;
        addr_chg_s   = (address_pins != addr_r);
        write_end_s  = (state_r == WRITE) & ~wr_s;
        commit_s     = write_end_s & (cnt_r >= WRITE_MIN_C);
        short_s      = write_end_s & (cnt_r < WRITE_MIN_C);
        contention_s = data_pins_out_en & data_pins_in_en;
    end

    // Access state machine with registered bus outputs and access counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= IDLE;
            cnt_r            <= 3'd0;
            addr_r           <= {ADDR_W{1'b0}};
            wdata_r          <= {DATA_W{1'b0}};
            data_pins_out    <= {DATA_W{1'b0}};
            data_pins_out_en <= 1'b0;
            write_count      <= 16'd0;
            read_count       <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    data_pins_out_en <= 1'b0;
                    if (wr_s) begin
                        state_r <= WRITE;
                        cnt_r   <= 3'd1;
                        addr_r  <= address_pins;
                        wdata_r <= data_pins_in;
                    end else if (rd_s) begin
                        state_r <= READ_ACCESS;
                        cnt_r   <= 3'd1;
                        addr_r  <= address_pins;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ_ACCESS: begin
                    if (wr_s) begin
                        state_r <= WRITE;
                        cnt_r   <= 3'd1;
                        addr_r  <= address_pins;
                        wdata_r <= data_pins_in;
                    end else if (!rd_s) begin
                        state_r <= IDLE;
                    end else if (addr_chg_s) begin
                        // Any address movement restarts the access time
                        cnt_r  <= 3'd1;
                        addr_r <= address_pins;
                    end else if (cnt_r == READ_LAT_C) begin
                        state_r          <= READ_VALID;
                        data_pins_out    <= mem_r[addr_r[DEPTH_LOG2-1:0]];
                        data_pins_out_en <= 1'b1;
                        read_count       <= read_count + 16'd1;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                READ_VALID: begin
                    if (wr_s) begin
                        state_r          <= WRITE;
                        data_pins_out_en <= 1'b0;
                        cnt_r            <= 3'd1;
                        addr_r           <= address_pins;
                        wdata_r          <= data_pins_in;
                    end else if (!rd_s) begin
                        state_r          <= IDLE;
                        data_pins_out_en <= 1'b0;
                    end else if (addr_chg_s) begin
                        state_r          <= READ_ACCESS;
                        data_pins_out_en <= 1'b0;
                        cnt_r            <= 3'd1;
                        addr_r           <= address_pins;
                    end else begin
                        data_pins_out_en <= 1'b1;
                    end
                end
                WRITE: begin
                    data_pins_out_en <= 1'b0;
                    if (wr_s) begin
                        // Last sampled address/data are what commit
                        addr_r  <= address_pins;
                        wdata_r <= data_pins_in;
                        cnt_r   <= (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + 3'd1;
                    end else begin
                        if (commit_s) begin
                            write_count <= write_count + 16'd1;
                        end else begin
                            write_count <= write_count;
                        end
                        if (rd_s) begin
                            state_r <= READ_ACCESS;
                            cnt_r   <= 3'd1;
                            addr_r  <= address_pins;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    data_pins_out_en <= 1'b0;
                end
            endcase
        end
    end

    // Backing array; not reset so contents survive a controller reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[addr_r[DEPTH_LOG2-1:0]] <= wdata_r;
        end
    end

    // Sticky protocol error flags; a fresh violation overrides a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_short_write <= 1'b0;
            err_contention  <= 1'b0;
        end else begin
            if (short_s) begin
                err_short_write <= 1'b1;
            end else if (clear_errors) begin
                err_short_write <= 1'b0;
            end else begin
                err_short_write <= err_short_write;
            end
            if (contention_s) begin
                err_contention <= 1'b1;
            end else if (clear_errors) begin
                err_contention <= 1'b0;
            end else begin
                err_contention <= err_contention;
            end
        end
    end

endmodule
